wb_cache_param: RTL and testbench



---
 rtl/cache_pkg.sv | 24 ++
 rtl/wb_cache_param_if.sv | 26 ++
 rtl/cache_line_store.sv | 60 ++++++
 rtl/wb_cache_param.sv | 143 ++++++++++++++
 tb/tb_wb_cache_param.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the parametrised write-back data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } cache_state_t;

  localparam int unsigned FIELD_MAX_W = 64;

  // Extract a field of 'width' bits starting at bit 'lsb' of a word address.
  function automatic logic [FIELD_MAX_W-1:0] addr_field(
    input logic [FIELD_MAX_W-1:0] addr,
    input int unsigned            lsb,
    input int unsigned            width
  );
    logic [FIELD_MAX_W-1:0] mask;
    mask = (width >= FIELD_MAX_W) ? '1
                                  : ((FIELD_MAX_W'(1) << width) - FIELD_MAX_W'(1));
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/wb_cache_param_if.sv
// Block-wide memory-side handshake between the cache (master) and main memory (slave).
interface wb_cache_param_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned OFFSET_W = 2
);
  localparam int unsigned BLOCK_W = DATA_W << OFFSET_W;
  localparam int unsigned BADDR_W = ADDR_W - OFFSET_W;

  logic               mm_req;
  logic               mm_we;
  logic [BADDR_W-1:0] mm_addr;
  logic [BLOCK_W-1:0] mm_wblock;
  logic [BLOCK_W-1:0] mm_rblock;
  logic               mm_ready;

  modport master (
    output mm_req, mm_we, mm_addr, mm_wblock,
    input  mm_rblock, mm_ready
  );

  modport slave (
    input  mm_req, mm_we, mm_addr, mm_wblock,
    output mm_rblock, mm_ready
  );
endinterface

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays of a direct-mapped cache: async line read,
// word write (sets dirty) and line refill (sets valid, clears dirty).
module cache_line_store #(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned INDEX_W  = 5,
  parameter  int unsigned OFFSET_W = 2,
  parameter  int unsigned TAG_W    = 3,
  localparam int unsigned BLOCK_W  = DATA_W << OFFSET_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid_c,
  output logic                rd_dirty_c,
  output logic [TAG_W-1:0]    rd_tag_c,
  output logic [BLOCK_W-1:0]  rd_block_c,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_block
);
  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  assign rd_valid_c = valid_q[rd_index];
  assign rd_dirty_c = dirty_q[rd_index];
  assign rd_tag_c   = tag_q[rd_index];
  assign rd_block_c = data_q[rd_index];

  // Line status bits are the only state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
      dirty_q[fill_index] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_block;
    end else if (wr_en) begin
      data_q[wr_index][32'(wr_offset) * DATA_W +: DATA_W] <= wr_data;
    end
  end

endmodule

// File: rtl/wb_cache_param.sv
// Direct-mapped write-back, write-allocate data cache with a block-wide
// request/ready memory port and saturating hit/miss counters.
module wb_cache_param
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   word_address,
  input  logic [DATA_W-1:0]   data_in,
  output logic                stall,
  output logic [DATA_W-1:0]   data_out,
  wb_cache_param_if.master    mm,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_W = DATA_W << OFFSET_W;
  localparam int unsigned BADDR_W = ADDR_W - OFFSET_W;

  if (ADDR_W <= INDEX_W + OFFSET_W) begin : g_geom_check
    $error("wb_cache_param: ADDR_W must exceed INDEX_W + OFFSET_W");
  end

  cache_state_t state_q, state_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                req_c;
  logic                hit_c;

  logic                rd_valid_c;
  logic                rd_dirty_c;
  logic [TAG_W-1:0]    rd_tag_c;
  logic [BLOCK_W-1:0]  rd_block_c;

  logic                mm_req_c;
  logic                mm_we_c;
  logic [BADDR_W-1:0]  mm_addr_c;
  logic                wr_en_c;
  logic                fill_en_c;
  logic                hit_inc_c;
  logic                miss_inc_c;

  assign req_offset = OFFSET_W'(addr_field(FIELD_MAX_W'(word_address), 0, OFFSET_W));
  assign req_index  = INDEX_W'(addr_field(FIELD_MAX_W'(word_address), OFFSET_W, INDEX_W));
  assign req_tag    = TAG_W'(addr_field(FIELD_MAX_W'(word_address), INDEX_W + OFFSET_W, TAG_W));

  cache_line_store #(
    .DATA_W   (DATA_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (req_index),
    .rd_valid_c (rd_valid_c),
    .rd_dirty_c (rd_dirty_c),
    .rd_tag_c   (rd_tag_c),
    .rd_block_c (rd_block_c),
    .wr_en      (wr_en_c),
    .wr_index   (req_index),
    .wr_offset  (req_offset),
    .wr_data    (data_in),
    .fill_en    (fill_en_c),
    .fill_index (req_index),
    .fill_tag   (req_tag),
    .fill_block (mm.mm_rblock)
  );

  assign req_c    = mem_read | mem_write;
  assign hit_c    = req_c & rd_valid_c & (rd_tag_c == req_tag);
  assign data_out = rd_block_c[32'(req_offset) * DATA_W +: DATA_W];
  assign stall    = (state_q != IDLE) | (req_c & ~hit_c);

  assign mm.mm_req    = mm_req_c;
  assign mm.mm_we     = mm_we_c;
  assign mm.mm_addr   = mm_addr_c;
  assign mm.mm_wblock = rd_block_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, memory request and array write enables.
  always_comb begin
    state_d    = state_q;
    mm_req_c   = 1'b0;
    mm_we_c    = 1'b0;
    mm_addr_c  = {req_tag, req_index};
    wr_en_c    = 1'b0;
    fill_en_c  = 1'b0;
    hit_inc_c  = 1'b0;
    miss_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_c) begin
          hit_inc_c = 1'b1;
          wr_en_c   = mem_write;
        end else if (req_c) begin
          miss_inc_c = 1'b1;
          state_d    = (rd_valid_c && rd_dirty_c) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mm_req_c  = 1'b1;
        mm_we_c   = 1'b1;
        mm_addr_c = {rd_tag_c, req_index};
        if (mm.mm_ready) state_d = REFILL;
      end
      REFILL: begin
        mm_req_c = 1'b1;
        if (mm.mm_ready) begin
          fill_en_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc_c && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc_c && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_cache_param.sv
// Directed bench for wb_cache_param: default-geometry instance plus a CNT_W=2 instance.
module tb_wb_cache_param;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        mem_read, mem_write;
  logic [9:0]  word_address;
  logic [31:0] data_in;
  logic        stall;
  logic [31:0] data_out;
  logic [15:0] hit_cnt, miss_cnt;

  logic        mem_read2;
  logic [9:0]  word_address2;
  logic        stall2;
  logic [31:0] data_out2;
  logic [1:0]  hit_cnt2, miss_cnt2;

  wb_cache_param_if #(.DATA_W(32), .ADDR_W(10), .OFFSET_W(2)) mm1 ();
  wb_cache_param_if #(.DATA_W(32), .ADDR_W(10), .OFFSET_W(2)) mm2 ();

  wb_cache_param dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .word_address(word_address), .data_in(data_in), .stall(stall), .data_out(data_out),
    .mm(mm1.master), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  wb_cache_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read2), .mem_write(1'b0),
    .word_address(word_address2), .data_in(32'h0), .stall(stall2), .data_out(data_out2),
    .mm(mm2.master), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
  );

  // Memory block contents: word w of block address a is {C0, a, 00, w}.
  function automatic logic [127:0] blk(input logic [7:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {8'hC0, a, 8'h00, 8'(w)};
    return b;
  endfunction

  // Memory responders: mm_ready pulses on the lat-th cycle of an mm_req phase.
  int   lat1 = 3, cnt1 = 0, lat2 = 1, cnt2 = 0;
  logic auto1 = 1'b0, man1 = 1'b0, auto2 = 1'b0;

  assign mm1.mm_rblock = blk(mm1.mm_addr);
  assign mm1.mm_ready  = auto1 | man1;
  assign mm2.mm_rblock = blk(mm2.mm_addr);
  assign mm2.mm_ready  = auto2;

  always @(negedge clk) begin
    if (!mm1.mm_req) begin cnt1 = 0; auto1 = 1'b0; end
    else begin cnt1 = auto1 ? 1 : cnt1 + 1; auto1 = (cnt1 == lat1); end
  end

  always @(negedge clk) begin
    if (!mm2.mm_req) begin cnt2 = 0; auto2 = 1'b0; end
    else begin cnt2 = auto2 ? 1 : cnt2 + 1; auto2 = (cnt2 == lat2); end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observations recorded while an access is stalled.
  int          n_stall;
  logic        first_req, req_seen, gap;
  logic [7:0]  wb_addr, rf_addr;
  logic [31:0] wb_word1;

  // Start an access just after a rising edge; return at the falling edge where stall is low.
  task automatic access1(input logic rd, input logic wr, input logic [9:0] addr, input logic [31:0] din);
    logic done;
    mem_read = rd; mem_write = wr; word_address = addr; data_in = din;
    n_stall = 0; first_req = 1'b0; req_seen = 1'b0; gap = 1'b0;
    wb_addr = '0; rf_addr = '0; wb_word1 = '0; done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (i == 0) first_req = mm1.mm_req;
      if (!stall) done = 1'b1;
      else begin
        n_stall++;
        if (mm1.mm_req) begin
          req_seen = 1'b1;
          if (mm1.mm_we) begin wb_addr = mm1.mm_addr; wb_word1 = mm1.mm_wblock[63:32]; end
          else rf_addr = mm1.mm_addr;
        end else if (req_seen) gap = 1'b1;
        @(posedge clk); #1;
      end
    end
    check("access_completes", stall, 1'b0);
  endtask

  task automatic finish1();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; word_address = '0; data_in = '0;
    mem_read2 = 1'b0; word_address2 = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_mm_req", mm1.mm_req, 1'b0);
    check("rst_mm_we", mm1.mm_we, 1'b0);
    check("rst_hit_cnt", hit_cnt, 16'd0);
    check("rst_miss_cnt", miss_cnt, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold load, clean miss, L=3
    lat1 = 3;
    access1(1'b1, 1'b0, 10'h085, 32'h0);
    check("cold_stalls", n_stall, 4);
    check("cold_req_delayed", first_req, 1'b0);
    check("cold_refill_addr", rf_addr, 8'h21);
    check("cold_done_req", mm1.mm_req, 1'b0);
    check("cold_done_we", mm1.mm_we, 1'b0);
    check("cold_data", data_out, 32'hC0210001);
    finish1();
    check("cold_miss_cnt", miss_cnt, 16'd1);
    check("cold_hit_cnt", hit_cnt, 16'd1);

    // Store hit then load hit
    access1(1'b0, 1'b1, 10'h085, 32'hDEADBEEF);
    check("store_stalls", n_stall, 0);
    finish1();
    access1(1'b1, 1'b0, 10'h085, 32'h0);
    check("load_stalls", n_stall, 0);
    check("load_no_req", req_seen, 1'b0);
    check("load_data", data_out, 32'hDEADBEEF);
    finish1();
    check("dirty_set", dut1.u_store.dirty_q[1], 1'b1);
    check("hits_3", hit_cnt, 16'd3);

    // Conflicting load evicts the dirty line, Lw=Lr=2
    lat1 = 2;
    access1(1'b1, 1'b0, 10'h105, 32'h0);
    check("evict_stalls", n_stall, 5);
    check("wb_addr", wb_addr, 8'h21);
    check("wb_word1", wb_word1, 32'hDEADBEEF);
    check("evict_refill_addr", rf_addr, 8'h41);
    check("wb_to_refill_gapless", gap, 1'b0);
    check("evict_data", data_out, 32'hC0410001);
    finish1();
    check("evict_miss_cnt", miss_cnt, 16'd2);
    check("evict_hit_cnt", hit_cnt, 16'd4);
    check("dirty_cleared", dut1.u_store.dirty_q[1], 1'b0);

    // Read and write together behave as a store
    access1(1'b1, 1'b1, 10'h106, 32'h12345678);
    check("rw_stalls", n_stall, 0);
    finish1();
    access1(1'b1, 1'b0, 10'h106, 32'h0);
    check("rw_data", data_out, 32'h12345678);
    finish1();
    check("rw_dirty", dut1.u_store.dirty_q[1], 1'b1);

    // Reset in the middle of a refill
    lat1 = 1000;
    mem_read = 1'b1; word_address = 10'h0C8;
    repeat (3) @(posedge clk);
    #1;
    check("mid_refill_req", mm1.mm_req, 1'b1);
    check("mid_refill_we", mm1.mm_we, 1'b0);
    check("mid_refill_addr", mm1.mm_addr, 8'h32);
    rst_n = 1'b0; mem_read = 1'b0;
    #2;
    check("async_rst_req", mm1.mm_req, 1'b0);
    check("async_rst_stall", stall, 1'b0);
    check("async_rst_hit_cnt", hit_cnt, 16'd0);
    check("async_rst_miss_cnt", miss_cnt, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1; man1 = 1'b1;
    @(posedge clk); #1 man1 = 1'b0;
    check("late_ready_req", mm1.mm_req, 1'b0);
    check("late_ready_stall", stall, 1'b0);
    check("late_ready_unfilled", dut1.u_store.valid_q[18], 1'b0);
    lat1 = 1;
    access1(1'b1, 1'b0, 10'h0C8, 32'h0);
    check("post_rst_stalls", n_stall, 2);
    check("post_rst_refill_addr", rf_addr, 8'h32);
    check("post_rst_data", data_out, 32'hC0320000);
    finish1();
    check("post_rst_miss_cnt", miss_cnt, 16'd1);
    check("post_rst_hit_cnt", hit_cnt, 16'd1);

    // CNT_W=2 instance: one miss then five hits saturate hit_cnt at 3
    mem_read2 = 1'b1; word_address2 = 10'h085;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall2) break;
      @(posedge clk); #1;
    end
    check("sat_fill_done", stall2, 1'b0);
    check("sat_data", data_out2, 32'hC0210001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("sat_hit_2", hit_cnt2, 2'd2);
    end
    mem_read2 = 1'b0;
    check("sat_hit_cnt", hit_cnt2, 2'd3);
    check("sat_miss_cnt", miss_cnt2, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
